// File: rtl/alu_pkg.sv
// Shared encodings for the nibble-serial ALU: operation codes, controller
// states and the width of the single arithmetic slice.
package alu_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    OP_XOR = 2'b00,
    OP_AND = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_nibble_sequencer_selector.sv
// Selector: 4-bit combinational ALU slice (XOR/AND/ADD/SUB) with carry in/out.
module alu_nibble_sequencer_selector
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic [1:0]         sel,
  output logic [SLICE_W-1:0] y,
  output logic               cout
);

  logic [SLICE_W:0] sum;
  logic [SLICE_W:0] diff;

  // Slice datapath; logic ops never produce a carry.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    diff = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, 1'b1};
    y    = '0;
    cout = 1'b0;
    case (sel)
      OP_XOR: y = a ^ b;
      OP_AND: y = a & b;
      OP_ADD: begin
        y    = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      default: begin
        y    = diff[SLICE_W-1:0];
        cout = diff[SLICE_W];
      end
    endcase
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial ALU: one shared 4-bit slice processes a W-bit operation,
// LSB nibble first, one nibble per clock, with valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | stepping the slice through nibbles 0..NIBBLES-1
// DONE  | result and flags held, out_valid high until consumed
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                       cin,
  input  logic [1:0]                 sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*NIBBLES-1:0] result,
  output logic                       carry_out,
  output logic                       zero,
  output logic                       overflow
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic               op_cin;
  op_e                op_sel;
  logic               carry_q;

  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_raw;
  logic [SLICE_W-1:0] b_nib;
  logic [1:0]         slice_sel;
  logic               slice_cin;
  logic [SLICE_W-1:0] slice_y;
  logic               slice_cout;
  logic               is_sub;
  logic               is_arith;
  logic               last;
  logic [W-1:0]       res_nxt;
  logic               b_msb_eff;
  logic               ovf_nxt;

  // Steer the current nibble into the slice; SUB is done as A + ~B + 1.
  always_comb begin
    a_nib = '0;
    b_raw = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IDX_W'(k)) begin
        a_nib = op_a[k*SLICE_W +: SLICE_W];
        b_raw = op_b[k*SLICE_W +: SLICE_W];
      end
    end
    is_sub    = (op_sel == OP_SUB);
    is_arith  = (op_sel == OP_ADD) || is_sub;
    b_nib     = is_sub ? ~b_raw : b_raw;
    slice_sel = is_arith ? OP_ADD : op_sel;
    if (idx == '0) begin
      slice_cin = is_sub ? 1'b1 : ((op_sel == OP_ADD) ? op_cin : 1'b0);
    end else begin
      slice_cin = is_arith ? carry_q : 1'b0;
    end
  end

  alu_nibble_sequencer_selector u_selector (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (slice_cin),
    .sel  (slice_sel),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // Merge the fresh nibble into the result and derive end-of-op flags.
  always_comb begin
    res_nxt = result;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IDX_W'(k)) begin
        res_nxt[k*SLICE_W +: SLICE_W] = slice_y;
      end
    end
    last      = (idx == IDX_W'(NIBBLES - 1));
    b_msb_eff = op_b[W-1] ^ is_sub;
    ovf_nxt   = is_arith && (op_a[W-1] == b_msb_eff) && (res_nxt[W-1] != op_a[W-1]);
  end

  // Controller FSM with registered handshake outputs and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_sel    <= OP_XOR;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= b;
            op_cin   <= cin;
            op_sel   <= op_e'(sel);
            idx      <= '0;
            carry_q  <= 1'b0;
            result   <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result  <= res_nxt;
          carry_q <= slice_cout;
          idx     <= idx + 1'b1;
          if (last) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            carry_out <= is_arith & slice_cout;
            overflow  <= ovf_nxt;
            zero      <= (res_nxt == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_nibble_sequencer.md
ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operation (operand width W = 4*NIBBLES).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  request present.
REQ-005 The block SHALL have port in_ready  output  1  request accepted when in_valid and in_ready both high.
REQ-006 The block SHALL have port a  input  W  operand A.
REQ-007 The block SHALL have port b  input  W  operand B.
REQ-008 The block SHALL have port cin  input  1  carry-in, used by ADD only.
REQ-009 The block SHALL have port sel  input  2  operation: 00 XOR, 01 AND, 10 ADD, 11 SUB.
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  result consumed when out_valid and out_ready both high.
REQ-012 The block SHALL have port result  output  W  operation result.
REQ-013 The block SHALL have port carry_out  output  1  final carry (ADD/SUB); SUB: 1 = no borrow.
REQ-014 The block SHALL have port zero  output  1  result == 0.
REQ-015 The block SHALL have port overflow  output  1  signed overflow (ADD/SUB).

Function
REQ-016 The block SHALL compute a W-bit operation by time-multiplexing a single 4-bit ALU slice, one nibble per clock, LSB nibble first.
REQ-017 The FSM SHALL have states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 On accept in IDLE, a, b, cin, sel SHALL be captured into operand registers, nibble index cleared to 0, state -> RUN; later input changes SHALL have no effect.
REQ-019 In RUN, each cycle SHALL compute nibble[idx], write it into result register bits [4*idx+3:4*idx], register the slice carry, and increment idx.
REQ-020 When idx = NIBBLES-1 completes, state SHALL -> DONE; out_valid SHALL rise exactly NIBBLES cycles after the accept edge.
REQ-021 In DONE, result and flags SHALL hold stable until out_valid && out_ready, then state -> IDLE (in_ready high next cycle); no back-to-back accept in DONE.
REQ-022 ADD: slice driven with sel=10, B nibble as-is; nibble 0 carry-in = captured cin, nibble k>0 carry-in = registered carry of nibble k-1.
REQ-023 SUB: slice driven with sel=10 (not 11), B nibble inverted by the controller; nibble 0 carry-in = 1, later nibbles chained; cin input ignored.
REQ-024 XOR/AND: slice driven with captured sel; carry chain ignored; carry_out = 0, overflow = 0.
REQ-025 overflow (ADD/SUB) SHALL be set when A[W-1] equals effective-B[W-1] and result[W-1] differs from them.
REQ-026 zero SHALL reflect the complete W-bit result, valid while out_valid = 1.
REQ-027 in_valid in RUN or DONE SHALL be ignored (no capture, no state change).

Reset
REQ-028 With rst high at a rising edge: state -> IDLE, idx = 0, result = 0, carry_out = 0, zero = 0, overflow = 0, out_valid = 0, in_ready = 1 on the following cycle.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no partial result delivered; reset SHALL take priority over accept and consume.

Structure
REQ-030 Shared package alu_pkg SHALL hold op encodings (OP_XOR, OP_AND, OP_ADD, OP_SUB), FSM state encodings, and the slice width constant 4.
REQ-031 The block SHALL instantiate exactly one Selector (existing 4-bit XOR/AND/ADD/SUB slice) as its sub-module; no other arithmetic instance.

Verification
REQ-032 ADD a=0x00FF b=0x0001 cin=0 -> result 0x0100, carry 0, zero 0, overflow 0, out_valid exactly 4 cycles after accept.
REQ-033 ADD a=0xFFFF b=0x0001 cin=0 -> 0x0000, carry 1, zero 1; ADD 0x7FFF+0x0001 -> 0x8000, overflow 1, carry 0.
REQ-034 SUB a=0x0000 b=0x0001 cin=1 -> 0xFFFF, carry 0, overflow 0; SUB 0x8000-0x0001 -> 0x7FFF, carry 1, overflow 1.
REQ-035 XOR 0xA5A5^0xFFFF -> 0x5A5A, carry 0; AND 0xF0F0&0x0FF0 -> 0x00F0, carry 0, overflow 0.
REQ-036 Backpressure: out_ready low 3 cycles in DONE with in_valid high and changing operands -> result/flags stable, in_ready 0, no new capture; out_ready high -> IDLE next cycle.
REQ-037 rst pulsed on second RUN cycle -> next cycle IDLE, all outputs 0, in_ready 1; subsequent ADD 0x0003+0x0004 -> 0x0007.
